ring_pattern_gen: RTL

//   Parametrised LED pattern sequencer with an integrated clock-enable prescaler.

---
 rtl/ring_pattern_gen.sv | 67 ++++++
 1 files changed

// File: rtl/ring_pattern_gen.sv
// ring_pattern_gen: prescaled LED pattern sequencer (rotate left/right, bounce, hold); SPEED_SEL_EN adds speed[1:0]
module ring_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV = 100,
  parameter logic [WIDTH-1:0] RESET_PAT = WIDTH'(8'h80)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef SPEED_SEL_EN
  input  logic [1:0]       speed,
`endif
  output logic [WIDTH-1:0] pattern,
  output logic             step,
  output logic             dir
);
`ifdef SPEED_SEL_EN
  localparam int CW = $clog2(DIV * 8);
  logic [CW-1:0] tc;
  assign tc = CW'((DIV << speed) - 1);
`else
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] tc;
  assign tc = CW'(DIV - 1);
`endif
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] nxt_pat;
  logic nxt_dir, nxt_step, tick, go_left;
  // >= lets a shortened period (speed drop) tick immediately and wrap
  assign tick = en & (cnt >= tc);
  assign go_left = dir ? pattern[0] : ~pattern[WIDTH-1];
  // next pattern/direction for a tick; hold mode neither moves nor pulses
  always_comb begin
    nxt_pat = pattern;
    nxt_dir = dir;
    nxt_step = 1'b0;
    if (tick && mode != 2'b11) begin
      nxt_step = 1'b1;
      nxt_pat = mode == 2'b00 ? {pattern[WIDTH-2:0], pattern[WIDTH-1]} :
                mode == 2'b01 ? {pattern[0], pattern[WIDTH-1:1]} :
                go_left ? pattern << 1 : pattern >> 1;
      nxt_dir = mode == 2'b10 ? ~go_left : dir;
    end
  end
  // prescaler and pattern registers; load overrides a coincident tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pattern <= RESET_PAT;
      dir <= 1'b0;
      step <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      pattern <= load_val;
      dir <= 1'b0;
      step <= 1'b0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + CW'(1);
      pattern <= nxt_pat;
      dir <= nxt_dir;
      step <= nxt_step;
    end
  end
endmodule
